button_io_mem: RTL and testbench

BUTTON_IO_MEM -- requirements
Module: button_io_mem

---
 rtl/button_io_pkg.sv | 23 ++
 rtl/button_debounce.sv | 60 ++++++
 rtl/button_io_mem.sv | 154 +++++++++++++++
 tb/tb_button_io_mem.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_io_pkg.sv
// Shared register map, count width and read-fill constants for the button I/O block.
// Optional interrupt support is enabled by defining BUTTON_IO_IRQ_EN.
package button_io_pkg;

    typedef enum logic [3:0] {
        REG_LEVEL    = 4'd0,
        REG_PRESS    = 4'd1,
        REG_RELEASE  = 4'd2,
        REG_IRQ_MASK = 4'd3,
        REG_CHAN_SEL = 4'd4,
        REG_COUNT    = 4'd5
    } reg_offset_e;

    localparam int COUNT_WIDTH = 8;

    // Every bit of an unmapped read is driven to this value.
    localparam logic UNMAPPED_FILL = 1'b1;

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] value);
        return (value == {COUNT_WIDTH{1'b1}}) ? value : value + COUNT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/button_debounce.sv
// One button channel: 2-flop synchroniser, stability counter, debounced level
// and single-cycle rise/fall pulses coincident with the level change.
module button_debounce
    import button_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic button_in,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             flip;

    // The counter only advances while the synchronised input disagrees with the level.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        flip    = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                flip    = 1'b1;
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= button_in;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign rise  = flip & ~level_q;
    assign fall  = flip & level_q;

endmodule

// File: rtl/button_io_mem.sv
// Memory-mapped debounced button block with press/release flags, per-channel
// press counters and an optional level interrupt (macro BUTTON_IO_IRQ_EN).
module button_io_mem
    import button_io_pkg::*;
#(
    parameter int DATA_WIDTH      = 16,
    parameter int ADDR_WIDTH      = 16,
    parameter int NUM_BUTTONS     = 8,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  data,
    input  logic [ADDR_WIDTH-1:0]  addr,
    input  logic                   en,
    input  logic                   we,
    input  logic [NUM_BUTTONS-1:0] buttons,
    output logic [DATA_WIDTH-1:0]  q,
    output logic                   irq
);

    // One spare code above the last channel so out-of-range selects are retained.
    localparam int SEL_W = $clog2(NUM_BUTTONS + 1);

    logic [NUM_BUTTONS-1:0] level;
    logic [NUM_BUTTONS-1:0] rise;
    logic [NUM_BUTTONS-1:0] fall;

    logic [NUM_BUTTONS-1:0] press_q;
    logic [NUM_BUTTONS-1:0] press_d;
    logic [NUM_BUTTONS-1:0] release_q;
    logic [NUM_BUTTONS-1:0] release_d;
    logic [NUM_BUTTONS-1:0] irq_mask_q;
    logic [NUM_BUTTONS-1:0] irq_mask_d;
    logic [SEL_W-1:0]       chan_sel_q;
    logic [SEL_W-1:0]       chan_sel_d;
    logic [COUNT_WIDTH-1:0] count_q [NUM_BUTTONS];
    logic [COUNT_WIDTH-1:0] count_d [NUM_BUTTONS];
    logic [DATA_WIDTH-1:0]  q_q;
    logic [DATA_WIDTH-1:0]  q_d;
    logic                   irq_q;
    logic                   irq_d;

    logic [DATA_WIDTH-1:0]  rdata;
    logic [COUNT_WIDTH-1:0] sel_count;
    logic [3:0]             offset;
    logic                   rd;
    logic                   wr;
    logic                   unused_bits;

    assign offset      = addr[3:0];
    assign rd          = en & ~we;
    assign wr          = en & we;
    assign unused_bits = &{1'b0, addr, data};

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk      (clk),
            .rst      (rst),
            .button_in(buttons[i]),
            .level    (level[i]),
            .rise     (rise[i]),
            .fall     (fall[i])
        );
    end

    always_comb begin
        sel_count = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            if (chan_sel_q == SEL_W'(i)) sel_count = count_q[i];
        end

        rdata = {DATA_WIDTH{UNMAPPED_FILL}};
        case (offset)
            REG_LEVEL:    rdata = DATA_WIDTH'(level);
            REG_PRESS:    rdata = DATA_WIDTH'(press_q);
            REG_RELEASE:  rdata = DATA_WIDTH'(release_q);
            REG_IRQ_MASK: rdata = DATA_WIDTH'(irq_mask_q);
            REG_CHAN_SEL: rdata = DATA_WIDTH'(chan_sel_q);
            REG_COUNT:    rdata = DATA_WIDTH'(sel_count);
            default:      ;
        endcase
    end

    // Bus writes are applied first; same-cycle debounce events then override them.
    always_comb begin
        press_d    = press_q;
        release_d  = release_q;
        chan_sel_d = chan_sel_q;
        q_d        = q_q;
        for (int i = 0; i < NUM_BUTTONS; i++) count_d[i] = count_q[i];

        if (wr) begin
            case (offset)
                REG_PRESS:    press_d    = press_q & ~data[NUM_BUTTONS-1:0];
                REG_RELEASE:  release_d  = release_q & ~data[NUM_BUTTONS-1:0];
                REG_CHAN_SEL: chan_sel_d = data[SEL_W-1:0];
                REG_COUNT: begin
                    for (int i = 0; i < NUM_BUTTONS; i++) begin
                        if (chan_sel_q == SEL_W'(i)) count_d[i] = '0;
                    end
                end
                default: ;
            endcase
        end

        press_d   = press_d | rise;
        release_d = release_d | fall;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            if (rise[i]) count_d[i] = sat_inc(count_d[i]);
        end

        if (rd) q_d = rdata;
    end

`ifdef BUTTON_IO_IRQ_EN
    always_comb begin
        irq_mask_d = irq_mask_q;
        if (wr && offset == REG_IRQ_MASK) irq_mask_d = data[NUM_BUTTONS-1:0];
        irq_d = |(press_q & irq_mask_q);
    end
`else
    always_comb begin
        irq_mask_d = '0;
        irq_d      = 1'b0;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            press_q    <= '0;
            release_q  <= '0;
            irq_mask_q <= '0;
            chan_sel_q <= '0;
            q_q        <= '0;
            irq_q      <= 1'b0;
            for (int i = 0; i < NUM_BUTTONS; i++) count_q[i] <= '0;
        end else begin
            press_q    <= press_d;
            release_q  <= release_d;
            irq_mask_q <= irq_mask_d;
            chan_sel_q <= chan_sel_d;
            q_q        <= q_d;
            irq_q      <= irq_d;
            for (int i = 0; i < NUM_BUTTONS; i++) count_q[i] <= count_d[i];
        end
    end

    assign q   = q_q;
    assign irq = irq_q;

endmodule

// File: tb/tb_button_io_mem.sv
// Self-checking bench for button_io_mem with a cycle-level behavioural model;
// the IRQ checks follow whether BUTTON_IO_IRQ_EN is defined for the build.
module tb_button_io_mem;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int NB = 8;
    localparam int DB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
    logic          en;
    logic          we;
    logic [NB-1:0] buttons;
    logic [DW-1:0] q;
    logic          irq;

    int checks = 0;
    int passes = 0;

    // Model state: raw pin history, debounced levels and the register file.
    bit [NB-1:0]   m_hist1, m_hist2, m_level, m_press, m_release, m_mask;
    int            m_run   [NB];
    int            m_count [NB];
    int            m_chan;
    logic [DW-1:0] m_q;
    bit            m_irq;

    button_io_mem #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .NUM_BUTTONS    (NB),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .data   (data),
        .addr   (addr),
        .en     (en),
        .we     (we),
        .buttons(buttons),
        .q      (q),
        .irq    (irq)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [DW-1:0] model_read(input int off);
        case (off)
            0: return DW'(m_level);
            1: return DW'(m_press);
            2: return DW'(m_release);
`ifdef BUTTON_IO_IRQ_EN
            3: return DW'(m_mask);
`else
            3: return '0;
`endif
            4: return DW'(m_chan);
            5: return (m_chan < NB) ? DW'(m_count[m_chan]) : '0;
            default: return 16'hFFFF;
        endcase
    endfunction

    task automatic model_reset();
        m_hist1 = '0; m_hist2 = '0; m_level = '0;
        m_press = '0; m_release = '0; m_mask = '0;
        m_chan = 0; m_q = '0; m_irq = 1'b0;
        for (int i = 0; i < NB; i++) begin
            m_run[i] = 0;
            m_count[i] = 0;
        end
    endtask

    // Advance the model across one rising edge using the currently driven inputs.
    task automatic model_step();
        bit [NB-1:0]   s, rise, fall;
        bit            clr;
        logic [DW-1:0] rd_val;
        bit            irq_next;
        rd_val = model_read(int'(addr[3:0]));
`ifdef BUTTON_IO_IRQ_EN
        irq_next = |(m_press & m_mask);
`else
        irq_next = 1'b0;
`endif
        s = m_hist2; m_hist2 = m_hist1; m_hist1 = buttons;
        rise = '0; fall = '0;
        for (int i = 0; i < NB; i++) begin
            if (s[i] != m_level[i]) begin
                m_run[i]++;
                if (m_run[i] == DB) begin
                    m_run[i] = 0;
                    if (s[i]) rise[i] = 1'b1; else fall[i] = 1'b1;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_level = m_level ^ (rise | fall);
        clr = 1'b0;
        if (en && we) begin
            case (int'(addr[3:0]))
                1: m_press = m_press & ~data[NB-1:0];
                2: m_release = m_release & ~data[NB-1:0];
                3: begin
`ifdef BUTTON_IO_IRQ_EN
                    m_mask = data[NB-1:0];
`endif
                end
                4: m_chan = int'(data);
                5: clr = 1'b1;
                default: ;
            endcase
        end
        for (int i = 0; i < NB; i++) begin
            if (clr && m_chan == i) m_count[i] = 0;
            if (rise[i] && m_count[i] < 255) m_count[i]++;
        end
        m_press = m_press | rise;
        m_release = m_release | fall;
        if (en && !we) m_q = rd_val;
        m_irq = irq_next;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [DW-1:0] v);
        en = 1'b1; we = 1'b0; addr = {12'($urandom), a};
        tick();
        en = 1'b0;
        v = q;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [DW-1:0] d);
        en = 1'b1; we = 1'b1; addr = {12'($urandom), a}; data = d;
        tick();
        en = 1'b0; we = 1'b0;
    endtask

    task automatic clear_flags();
        bus_write(4'd1, 16'hFFFF);
        bus_write(4'd2, 16'hFFFF);
    endtask

    task automatic test_reset();
        logic [DW-1:0] v;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q !== 16'h0000) $display("[TB] FAIL reset_q: got %h expected %h", q, 16'h0000);
        else passes++;
        checks++;
        if (irq !== 1'b0) $display("[TB] FAIL reset_irq: got %b expected 0", irq);
        else passes++;
        rst = 1'b0;
        for (int off = 0; off < 6; off++) begin
            bus_read(4'(off), v);
            checks++;
            if (v !== 16'h0000) $display("[TB] FAIL reset_reg%0d: got %h expected %h", off, v, 16'h0000);
            else passes++;
        end
    endtask

    task automatic test_press_latency();
        logic [DW-1:0] v;
        buttons[2] = 1'b1;
        idle(5);
        bus_read(4'd0, v);
        checks++;
        if (v !== 16'h0000) $display("[TB] FAIL level_early: got %h expected %h", v, 16'h0000);
        else passes++;
        bus_read(4'd0, v);
        checks++;
        if (v !== 16'h0004) $display("[TB] FAIL level_ch2: got %h expected %h", v, 16'h0004);
        else passes++;
        bus_read(4'd1, v);
        checks++;
        if (v !== 16'h0004) $display("[TB] FAIL press_ch2: got %h expected %h", v, 16'h0004);
        else passes++;
        bus_write(4'd4, 16'd2);
        bus_read(4'd5, v);
        checks++;
        if (v !== 16'h0001) $display("[TB] FAIL count_ch2: got %h expected %h", v, 16'h0001);
        else passes++;
        buttons[2] = 1'b0;
        idle(8);
        bus_read(4'd2, v);
        checks++;
        if (v !== 16'h0004) $display("[TB] FAIL release_ch2: got %h expected %h", v, 16'h0004);
        else passes++;
        clear_flags();
    endtask

    task automatic test_glitch();
        logic [DW-1:0] v;
        buttons[0] = 1'b1;
        idle(3);
        buttons[0] = 1'b0;
        idle(8);
        bus_read(4'd0, v);
        checks++;
        if (v !== 16'h0000) $display("[TB] FAIL glitch_level: got %h expected %h", v, 16'h0000);
        else passes++;
        bus_read(4'd1, v);
        checks++;
        if (v !== 16'h0000) $display("[TB] FAIL glitch_press: got %h expected %h", v, 16'h0000);
        else passes++;
        buttons[0] = 1'b1;
        idle(4);
        buttons[0] = 1'b0;
        idle(8);
        bus_read(4'd1, v);
        checks++;
        if (v !== 16'h0001) $display("[TB] FAIL hold4_press: got %h expected %h", v, 16'h0001);
        else passes++;
        clear_flags();
    endtask

    task automatic test_irq();
        logic [DW-1:0] v;
`ifdef BUTTON_IO_IRQ_EN
        bus_write(4'd3, 16'h0004);
        bus_read(4'd3, v);
        checks++;
        if (v !== 16'h0004) $display("[TB] FAIL irq_mask_rd: got %h expected %h", v, 16'h0004);
        else passes++;
        buttons[2] = 1'b1;
        idle(8);
        checks++;
        if (irq !== 1'b1) $display("[TB] FAIL irq_set: got %b expected 1", irq);
        else passes++;
        bus_write(4'd1, 16'h0004);
        checks++;
        if (irq !== m_irq) $display("[TB] FAIL irq_delay: got %b expected %b", irq, m_irq);
        else passes++;
        tick();
        checks++;
        if (irq !== 1'b0) $display("[TB] FAIL irq_clear: got %b expected 0", irq);
        else passes++;
        bus_write(4'd3, 16'h0000);
`else
        bus_write(4'd3, 16'h00FF);
        bus_read(4'd3, v);
        checks++;
        if (v !== 16'h0000) $display("[TB] FAIL mask_disabled: got %h expected %h", v, 16'h0000);
        else passes++;
        buttons[2] = 1'b1;
        idle(8);
        checks++;
        if (irq !== 1'b0) $display("[TB] FAIL irq_disabled: got %b expected 0", irq);
        else passes++;
`endif
        buttons[2] = 1'b0;
        idle(8);
        clear_flags();
    endtask

    task automatic test_w1c_collision();
        logic [DW-1:0] v;
        buttons[2] = 1'b1;
        idle(5);
        bus_write(4'd1, 16'h0004);
        bus_read(4'd1, v);
        checks++;
        if (v !== 16'h0004) $display("[TB] FAIL w1c_collision: got %h expected %h", v, 16'h0004);
        else passes++;
        buttons[2] = 1'b0;
        idle(8);
        clear_flags();
    endtask

    task automatic test_count_saturation();
        logic [DW-1:0] v;
        bus_write(4'd4, 16'd5);
        bus_write(4'd5, 16'h0000);
        for (int n = 0; n < 256; n++) begin
            buttons[5] = 1'b1;
            idle(6);
            buttons[5] = 1'b0;
            idle(6);
        end
        bus_read(4'd5, v);
        checks++;
        if (v !== 16'h00FF) $display("[TB] FAIL count_sat: got %h expected %h", v, 16'h00FF);
        else passes++;
        bus_write(4'd5, 16'($urandom));
        bus_read(4'd5, v);
        checks++;
        if (v !== 16'h0000) $display("[TB] FAIL count_clear: got %h expected %h", v, 16'h0000);
        else passes++;
        bus_read(4'd9, v);
        checks++;
        if (v !== 16'hFFFF) $display("[TB] FAIL unmapped_rd: got %h expected %h", v, 16'hFFFF);
        else passes++;
        buttons[5] = 1'b1;
        idle(5);
        bus_write(4'd5, 16'h0000);
        bus_read(4'd5, v);
        checks++;
        if (v !== 16'h0001) $display("[TB] FAIL count_inc_clr: got %h expected %h", v, 16'h0001);
        else passes++;
        buttons[5] = 1'b0;
        idle(8);
        clear_flags();
    endtask

    task automatic test_chan_sel_range();
        logic [DW-1:0] v;
        bus_write(4'd4, 16'd8);
        bus_read(4'd4, v);
        checks++;
        if (v !== 16'd8) $display("[TB] FAIL chan_sel_oob_rd: got %h expected %h", v, 16'd8);
        else passes++;
        bus_read(4'd5, v);
        checks++;
        if (v !== 16'h0000) $display("[TB] FAIL count_oob: got %h expected %h", v, 16'h0000);
        else passes++;
        bus_write(4'd4, 16'd5);
        bus_read(4'd5, v);
        checks++;
        if (v !== model_read(5) || v !== 16'h0001)
            $display("[TB] FAIL count_after_oob: got %h expected %h", v, 16'h0001);
        else passes++;
    endtask

    task automatic test_random();
        logic [DW-1:0] v;
        logic [3:0]    a;
        logic [DW-1:0] d;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 3) == 0) buttons[$urandom_range(0, NB - 1)] ^= 1'b1;
            a = 4'($urandom);
            case ($urandom_range(0, 2))
                0: tick();
                1: begin
                    bus_read(a, v);
                    checks++;
                    if (v !== m_q) $display("[TB] FAIL rand_read@%0h: got %h expected %h", a, v, m_q);
                    else passes++;
                end
                default: begin
                    d = (a == 4'd4) ? DW'($urandom_range(0, NB + 3)) : DW'($urandom);
                    bus_write(a, d);
                end
            endcase
            checks++;
            if (irq !== m_irq) $display("[TB] FAIL rand_irq: got %b expected %b", irq, m_irq);
            else passes++;
        end
    endtask

    task automatic test_reset_mid_debounce();
        logic [DW-1:0] v;
        buttons = '0;
        idle(10);
        buttons[3] = 1'b1;
        idle(4);
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (q !== 16'h0000 || irq !== 1'b0)
            $display("[TB] FAIL async_reset: got q=%h irq=%b expected q=0000 irq=0", q, irq);
        else passes++;
        buttons = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(10);
        for (int off = 0; off < 6; off++) begin
            bus_read(4'(off), v);
            checks++;
            if (v !== 16'h0000) $display("[TB] FAIL midreset_reg%0d: got %h expected %h", off, v, 16'h0000);
            else passes++;
        end
        rst = 1'b1;
        model_reset();
        buttons[4] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(5);
        bus_read(4'd1, v);
        checks++;
        if (v !== 16'h0000) $display("[TB] FAIL held_early: got %h expected %h", v, 16'h0000);
        else passes++;
        bus_read(4'd1, v);
        checks++;
        if (v !== 16'h0010) $display("[TB] FAIL held_press: got %h expected %h", v, 16'h0010);
        else passes++;
    endtask

    initial begin
        data = '0; addr = '0; en = 1'b0; we = 1'b0; buttons = '0;
        rst = 1'b1;
        model_reset();
        test_reset();
        test_press_latency();
        test_glitch();
        test_irq();
        test_w1c_collision();
        test_count_saturation();
        test_chan_sel_range();
        test_random();
        test_reset_mid_debounce();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
